// File: rtl/mux_sel_pipe.sv
// Encoded N-input word selector with a registered output stage for operand forwarding.
// Registered stage supports flush > stall > load, with sticky/saturating illegal-select tracking.
module mux_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_comb,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        err_cnt
);

    logic illegal;

    always_comb begin
        out_comb = '0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            if (select == SEL_W'(k))
                out_comb = in_bus[(k-1)*WIDTH +: WIDTH];
        end
    end

    // Select 0 is flagged too: forwarding control must never request a zero operand.
    assign illegal = (select == '0) || (select > SEL_W'(NUM_IN));

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            err_cnt   <= '0;
        end else if (flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_data  <= out_comb;
            out_valid <= in_valid;
            if (in_valid && illegal) begin
                sel_err <= 1'b1;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Self-checking bench for mux_sel_pipe: directed table, corner sequences, randomized model check.
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: default parameters
    logic         rst_a, v_a, st_a, fl_a;
    logic [3:0]   sel_a;
    logic [127:0] bus_a;
    logic [31:0]  comb_a, data_a;
    logic         valid_a, err_a;
    logic [7:0]   cnt_a;

    mux_sel_pipe u_a (
        .clk(clk), .reset(rst_a), .select(sel_a), .in_bus(bus_a),
        .in_valid(v_a), .stall(st_a), .flush(fl_a),
        .out_comb(comb_a), .out_data(data_a), .out_valid(valid_a),
        .sel_err(err_a), .err_cnt(cnt_a)
    );

    // Instance B: narrow data, six inputs, 2-bit counter
    logic        rst_b, v_b, st_b, fl_b;
    logic [2:0]  sel_b;
    logic [47:0] bus_b;
    logic [7:0]  comb_b, data_b;
    logic        valid_b, err_b;
    logic [1:0]  cnt_b;

    mux_sel_pipe #(.WIDTH(8), .NUM_IN(6), .SEL_W(3), .CNT_W(2)) u_b (
        .clk(clk), .reset(rst_b), .select(sel_b), .in_bus(bus_b),
        .in_valid(v_b), .stall(st_b), .flush(fl_b),
        .out_comb(comb_b), .out_data(data_b), .out_valid(valid_b),
        .sel_err(err_b), .err_cnt(cnt_b)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic        v, st, fl;
        logic [31:0] comb, data;
        logic        valid, err;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [3:0] sel, input logic v, st, fl,
                                input logic [31:0] comb, data,
                                input logic valid, err, input logic [7:0] cnt);
        vec_t r;
        r.sel = sel; r.v = v; r.st = st; r.fl = fl;
        r.comb = comb; r.data = data; r.valid = valid; r.err = err; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string nm, input logic [31:0] d, input logic vl, er,
                         input logic [7:0] c);
        chk({nm, ".data"}, data_a, d);
        chk({nm, ".valid"}, 32'(valid_a), 32'(vl));
        chk({nm, ".err"}, 32'(err_a), 32'(er));
        chk({nm, ".cnt"}, 32'(cnt_a), 32'(c));
    endtask

    task automatic chk_b(input string nm, input logic [7:0] d, input logic vl, er,
                         input logic [1:0] c);
        chk({nm, ".data"}, 32'(data_b), 32'(d));
        chk({nm, ".valid"}, 32'(valid_b), 32'(vl));
        chk({nm, ".err"}, 32'(err_b), 32'(er));
        chk({nm, ".cnt"}, 32'(cnt_b), 32'(c));
    endtask

    logic [31:0] w[4];
    logic [31:0] m_data, m_comb;
    logic        m_valid, m_err;
    int          m_cnt;

    initial begin
        rst_a = 1'b0; sel_a = 4'd1; v_a = 1'b1; st_a = 1'b0; fl_a = 1'b0;
        bus_a = '1;
        rst_b = 1'b0; sel_b = 3'd0; v_b = 1'b0; st_b = 1'b0; fl_b = 1'b0;
        bus_b = {8'hA5, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

        // Reset hold with all-ones inputs and a valid legal select
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_a($sformatf("reset_hold%0d", i), 32'h0, 1'b0, 1'b0, 8'd0);
        end
        rst_a = 1'b1;
        bus_a = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        tbl[0]  = mk(4'd1, 1, 0, 0, 32'h11111111, 32'h11111111, 1, 0, 8'd0);
        tbl[1]  = mk(4'd2, 1, 0, 0, 32'h22222222, 32'h22222222, 1, 0, 8'd0);
        tbl[2]  = mk(4'd3, 1, 0, 0, 32'h33333333, 32'h33333333, 1, 0, 8'd0);
        tbl[3]  = mk(4'd4, 1, 0, 0, 32'h44444444, 32'h44444444, 1, 0, 8'd0);
        tbl[4]  = mk(4'd3, 1, 0, 0, 32'h33333333, 32'h33333333, 1, 0, 8'd0);
        tbl[5]  = mk(4'd4, 1, 1, 0, 32'h44444444, 32'h33333333, 1, 0, 8'd0);
        tbl[6]  = mk(4'd4, 1, 1, 0, 32'h44444444, 32'h33333333, 1, 0, 8'd0);
        tbl[7]  = mk(4'd4, 1, 1, 0, 32'h44444444, 32'h33333333, 1, 0, 8'd0);
        tbl[8]  = mk(4'd4, 1, 1, 1, 32'h44444444, 32'h00000000, 0, 0, 8'd0);
        tbl[9]  = mk(4'd0, 1, 0, 0, 32'h00000000, 32'h00000000, 1, 1, 8'd1);
        tbl[10] = mk(4'd7, 1, 0, 0, 32'h00000000, 32'h00000000, 1, 1, 8'd2);
        tbl[11] = mk(4'd7, 0, 0, 0, 32'h00000000, 32'h00000000, 0, 1, 8'd2);
        tbl[12] = mk(4'd7, 1, 1, 0, 32'h00000000, 32'h00000000, 0, 1, 8'd2);
        tbl[13] = mk(4'd2, 0, 0, 0, 32'h22222222, 32'h22222222, 0, 1, 8'd2);
        tbl[14] = mk(4'd9, 1, 0, 1, 32'h00000000, 32'h00000000, 0, 1, 8'd2);
        tbl[15] = mk(4'd15, 1, 0, 0, 32'h00000000, 32'h00000000, 1, 1, 8'd3);
        tbl[16] = mk(4'd1, 1, 0, 0, 32'h11111111, 32'h11111111, 1, 1, 8'd3);

        foreach (tbl[i]) begin
            sel_a = tbl[i].sel; v_a = tbl[i].v; st_a = tbl[i].st; fl_a = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d.comb", i), comb_a, tbl[i].comb);
            tick();
            chk_a($sformatf("tbl%0d", i), tbl[i].data, tbl[i].valid, tbl[i].err, tbl[i].cnt);
        end

        // Reset asserted during a stall discards the held word and error state
        sel_a = 4'd2; v_a = 1'b1; st_a = 1'b1; fl_a = 1'b1; rst_a = 1'b0;
        tick();
        chk_a("reset_mid_stall", 32'h0, 1'b0, 1'b0, 8'd0);
        rst_a = 1'b1; st_a = 1'b0; fl_a = 1'b0;

        // Instance B: generality, saturation and mid-sequence reset
        tick();
        rst_b = 1'b1;
        sel_b = 3'd6; v_b = 1'b1;
        #1;
        chk("b.comb6", 32'(comb_b), 32'h000000A5);
        tick();
        chk_b("b.sel6", 8'hA5, 1'b1, 1'b0, 2'd0);
        sel_b = 3'd7;
        tick();
        chk_b("b.sel7", 8'h00, 1'b1, 1'b1, 2'd1);
        rst_b = 1'b0;
        tick();
        chk_b("b.reset", 8'h00, 1'b0, 1'b0, 2'd0);
        rst_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] want;
            want = (i < 3) ? 2'(i + 1) : 2'd3;
            sel_b = (i % 2 == 0) ? 3'd0 : 3'd7;
            tick();
            chk_b($sformatf("b.sat%0d", i), 8'h00, 1'b1, 1'b1, want);
        end
        sel_b = 3'd6;
        tick();
        chk_b("b.after_sat", 8'hA5, 1'b1, 1'b1, 2'd3);
        rst_b = 1'b0;
        tick();
        chk_b("b.reset_mid", 8'h00, 1'b0, 1'b0, 2'd0);
        rst_b = 1'b1;

        // Randomized run on instance A against a behavioural model
        rst_a = 1'b0;
        tick();
        m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            int s;
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            bus_a = {w[3], w[2], w[1], w[0]};
            s     = $urandom_range(0, 15);
            sel_a = 4'(s);
            v_a   = 1'($urandom_range(0, 1));
            st_a  = ($urandom_range(0, 3) == 0);
            fl_a  = ($urandom_range(0, 7) == 0);
            rst_a = ($urandom_range(0, 39) != 0);
            m_comb = (s >= 1 && s <= 4) ? w[s-1] : 32'h0;
            #1;
            chk($sformatf("rnd%0d.comb", n), comb_a, m_comb);
            if (!rst_a) begin
                m_data = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
            end else if (fl_a) begin
                m_data = '0; m_valid = 1'b0;
            end else if (!st_a) begin
                m_data  = m_comb;
                m_valid = v_a;
                if (v_a && (s == 0 || s > 4)) begin
                    m_err = 1'b1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
            end
            tick();
            chk_a($sformatf("rnd%0d", n), m_data, m_valid, m_err, 8'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
